// File: rtl/serial_add_sched.sv
// serial_add_sched
//   Digit-serial adder shared between two requesters. One 2-bit adder slice
//   processes one digit per cycle. A registered carry links the digits.
//   A round-robin priority bit picks between the requesters when both are
//   valid.
//
// Ports
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   req0_valid/ready/a/b           requester 0 operand handshake
//   req1_valid/ready/a/b           requester 1 operand handshake
//   res_valid/ready                result handshake
//   res_sum, res_carry, res_id     (a+b) mod 2^WIDTH, bit WIDTH of a+b, issuing requester
//   busy                           high whenever the scheduler is not idle
module serial_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic             busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The shared slice: {carry_out, sum[1:0]} of a 2-bit add with carry-in.
  function automatic logic [2:0] adder_2bit(input logic [1:0] x,
                                            input logic [1:0] y,
                                            input logic       cin);
    adder_2bit = {1'b0, x} + {1'b0, y} + {2'b00, cin};
  endfunction

  state_t           state_r;
  logic             prio_r;
  logic             id_r;
  logic             carry_r;
  logic [KW-1:0]    k_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;

  logic             gnt_s;
  logic             gnt_id_s;
  int               idx_s;
  logic [2:0]       slice_s;
  logic [WIDTH-1:0] sum_next_s;

  // Grant selection and combinational ready; nothing is granted during reset.
  always_comb begin
    gnt_s    = 1'b0;
    gnt_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id_s = prio_r;
    end else if (req1_valid) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
    if (!rst && (state_r == IDLE) && (req0_valid || req1_valid)) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    req0_ready = gnt_s && !gnt_id_s;
    req1_ready = gnt_s && gnt_id_s;
  end

  // Current digit through the slice; sum_next_s is the partial sum with this digit merged.
  always_comb begin
    idx_s      = 2 * int'(k_r);
    slice_s    = adder_2bit(a_r[idx_s +: 2], b_r[idx_s +: 2], carry_r);
    sum_next_s = sum_r;
    sum_next_s[idx_s +: 2] = slice_s[1:0];
  end

  // Scheduler FSM with registered result and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      prio_r    <= 1'b0;
      id_r      <= 1'b0;
      carry_r   <= 1'b0;
      k_r       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_s) begin
            a_r     <= gnt_id_s ? req1_a : req0_a;
            b_r     <= gnt_id_s ? req1_b : req0_b;
            id_r    <= gnt_id_s;
            prio_r  <= !gnt_id_s;
            carry_r <= 1'b0;
            k_r     <= '0;
            sum_r   <= '0;
            state_r <= RUN;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        RUN: begin
          sum_r   <= sum_next_s;
          carry_r <= slice_s[2];
          if (k_r == K_LAST) begin
            // Outputs are only loaded here, so they stay put through backpressure.
            res_sum   <= sum_next_s;
            res_carry <= slice_s[2];
            res_id    <= id_r;
            res_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            res_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
